logic_op_arbiter: RTL and testbench



---
 rtl/logic_arb_pkg.sv | 16 +
 rtl/logic_op_unit.sv | 24 ++
 rtl/logic_op_arbiter.sv | 123 ++++++++++++
 tb/tb_logic_op_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_arb_pkg.sv
// Shared types for the round-robin logic-op arbiter:
// FSM state encoding and bitwise opcode values.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/logic_op_unit.sv
// Shared combinational bitwise unit: AND / OR / XOR / NAND
// selected by a 2-bit opcode.
module logic_op_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between NREQ clients.
// Define LOGIC_OPSEL_EN to add per-requester opcodes (op_sel port).
module logic_op_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
`ifdef LOGIC_OPSEL_EN
  input  logic [NREQ*2-1:0]     op_sel,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_cur;
  logic [WIDTH-1:0] result;

  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  // First set request at or above ptr, wrapping to 0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_vld && req[(int'(ptr) + i) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = IDW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  assign a_sel = op_a[int'(win_idx)*WIDTH +: WIDTH];
  assign b_sel = op_b[int'(win_idx)*WIDTH +: WIDTH];

`ifdef LOGIC_OPSEL_EN
  logic [1:0] op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OP_AND;
    end else if (state == IDLE && win_vld) begin
      op_q <= op_sel[int'(win_idx)*2 +: 2];
    end
  end

  assign op_cur = op_q;
`else
  assign op_cur = OP_AND;
`endif

  logic_op_unit #(
    .WIDTH(WIDTH)
  ) u_unit (
    .op (op_cur),
    .a  (a_q),
    .b  (b_q),
    .y  (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      win_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt <= '0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            win_q <= win_idx;
            a_q   <= a_sel;
            b_q   <= b_sel;
            gnt   <= NREQ'(1) << win_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_id    <= win_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (win_q == IDW'(NREQ - 1))
                         ? '0 : win_q + IDW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed testbench for logic_op_arbiter (NREQ=4, WIDTH=8).
// Opcode vectors run only when LOGIC_OPSEL_EN is defined.
module tb_logic_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  op_sel;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic_op_arbiter #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef LOGIC_OPSEL_EN
    .op_sel    (op_sel),
`endif
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    logic [7:0]  d;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_id"}, 32'(rsp_id), 0);
    chk({tag, "_data"}, 32'(rsp_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Bounded wait for a grant; returns cycles taken (99 on timeout).
  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (gnt == 4'b0 && n < 12);
    if (gnt == 4'b0) n = 99;
  endtask

  task automatic run_txn(input string tag,
                         input logic [3:0] r,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int id,
                         input logic [7:0] d);
    int n;
    req = r;
    op_a = a;
    op_b = b;
    rsp_ready = 1'b1;
    wait_gnt(n);
    chk({tag, "_lat"}, 32'(n), 1);
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b1 << id));
    req = 4'b0;
    step();
    chk({tag, "_valid"}, 32'(rsp_valid), 1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_data"}, 32'(rsp_data), 32'(d));
    step();
    chk({tag, "_done"}, 32'({rsp_valid, busy}), 0);
  endtask

  initial begin
    int n;
    int last;
    logic [1:0] hid;
    logic [7:0] hdata;

    vecs[0] = '{4'b0001, 32'h010203F0, 32'hFFFFFF3C, 0, 8'h30};
    vecs[1] = '{4'b0001, 32'h000000FF, 32'h0000000F, 0, 8'h0F};
    vecs[2] = '{4'b0101, 32'h77AA6655, 32'h00CCFFFF, 2, 8'h88};
    vecs[3] = '{4'b1001, 32'h5A0000FF, 32'hFF0000FF, 3, 8'h5A};
    vecs[4] = '{4'b1001, 32'h5A000012, 32'hFF000036, 0, 8'h12};
    vecs[5] = '{4'b1110, 32'h0000C300, 32'h00003F00, 1, 8'h03};

    rst_n = 1'b0;
    req = '0;
    op_a = '0;
    op_b = '0;
    op_sel = '0;
    rsp_ready = 1'b1;
    repeat (3) step();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    step();
    chk_reset_outs("idle");

    // All four requesting: grants 0,1,2,3,0, three cycles apart.
    req = 4'b1111;
    op_a = 32'h44332211;
    op_b = 32'hFFFFFFFF;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      chk("rr_gnt", 32'(gnt), 32'(4'b1 << (k % 4)));
      if (k > 0) chk("rr_gap", 32'(cyc - last), 3);
      last = cyc;
      if (k == 4) req = 4'b0;
      step();
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_data", 32'(rsp_data), 32'(8'h11 * ((k % 4) + 1)));
    end
    step();
    chk("rr_idle", 32'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].a,
              vecs[i].b, vecs[i].id, vecs[i].d);
    end

    // Back-pressure: ptr=2, req=0010 -> requester 1.
    rsp_ready = 1'b0;
    req = 4'b0010;
    op_a = 32'h0000E700;
    op_b = 32'h00007E00;
    wait_gnt(n);
    chk("bp_gnt", 32'(gnt), 32'h2);
    req = 4'b1111;
    step();
    chk("bp_valid", 32'(rsp_valid), 1);
    hid = rsp_id;
    hdata = rsp_data;
    chk("bp_id", 32'(hid), 1);
    chk("bp_data", 32'(hdata), 32'h66);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_data, gnt, busy}),
          32'({1'b1, hid, hdata, 4'b0, 1'b1}));
    end
    rsp_ready = 1'b1;
    req = 4'b0;
    step();
    chk("bp_release", 32'({rsp_valid, busy}), 0);

    // Reset mid-RESP: ptr=2, req=0001 -> requester 0.
    rsp_ready = 1'b0;
    req = 4'b0001;
    op_a = 32'h000000FF;
    op_b = 32'h000000AA;
    wait_gnt(n);
    chk("mr_gnt", 32'(gnt), 32'h1);
    req = 4'b0;
    step();
    chk("mr_valid", 32'(rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mr_async");
    step();
    rst_n = 1'b1;
    step();
    chk_reset_outs("mr_after");
    run_txn("mr_ptr0", 4'b0101, 32'h00110022, 32'h00FF00FF, 0, 8'h22);
    run_txn("mr_req2", 4'b0100, 32'h00C30000, 32'h00F00000, 2, 8'hC0);

`ifdef LOGIC_OPSEL_EN
    op_sel = 8'b00000010;
    run_txn("op_xor", 4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'hA5);
    op_sel = 8'b00000011;
    run_txn("op_nand", 4'b0001, 32'h000000AA, 32'h0000000F, 0, 8'hF5);
    op_sel = 8'b00000100;
    run_txn("op_or", 4'b0010, 32'h0000A000, 32'h00000500, 1, 8'hA5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
